// File: rtl/acl_tilt_filter.sv
// Tilt detector for the accelerometer word: synchronizes and debounces acl_data,
// block-averages the Y axis and drives hysteresis-filtered left/right tilt levels.
module acl_tilt_filter #(
  parameter int SAMPLE_DIV    = 100000,
  parameter int AVG_LOG2      = 3,
  parameter int ENTER_TH      = 4,
  parameter int EXIT_TH       = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] acl_data,
  output logic        tilt_left,
  output logic        tilt_right,
  output logic [4:0]  avg_y,
  output logic        avg_valid,
  output logic [14:0] acl_stable
);

  localparam int DW    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW    = $clog2(STABLE_CYCLES + 1);
  localparam int ACC_W = 5 + AVG_LOG2;

  localparam logic [DW-1:0]      DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0]      STAB_MAX = CW'(STABLE_CYCLES);
  localparam logic signed [5:0]  ENTER_P  = 6'(ENTER_TH);
  localparam logic signed [5:0]  ENTER_N  = -6'(ENTER_TH);
  localparam logic signed [5:0]  EXIT_P   = 6'(EXIT_TH);
  localparam logic signed [5:0]  EXIT_N   = -6'(EXIT_TH);

  typedef enum logic [1:0] {ST_CENTER, ST_LEFT, ST_RIGHT} state_t;

  logic [14:0]             sync1_q, sync2_q, prev_q;
  logic [CW-1:0]           stab_cnt_q, stab_cnt_d;
  logic [14:0]             stable_q, stable_d;
  logic [DW-1:0]           div_q, div_d;
  logic [AVG_LOG2-1:0]     samp_q, samp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]              avg_y_q, avg_y_d;
  logic                    avg_valid_q, avg_valid_d;
  state_t                  state_q, state_d;

  logic                    tick, block_done;
  logic signed [ACC_W-1:0] sample, sum;
  logic signed [4:0]       avg;
  logic signed [5:0]       avg_ext;
  logic                    unused_sum_low;

  assign tick       = (div_q == DIV_LAST);
  assign block_done = tick && (samp_q == '1);
  assign sample     = ACC_W'($signed(stable_q[9:5]));
  assign sum        = acc_q + sample;
  // Taking bits above the shift is an arithmetic shift right, i.e. floor toward -inf.
  assign avg        = sum[AVG_LOG2 +: 5];
  assign avg_ext    = {avg[4], avg};
  assign unused_sum_low = ^sum[AVG_LOG2-1:0];

  always_comb begin
    stab_cnt_d = stab_cnt_q;
    stable_d   = stable_q;
    if (sync2_q != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q < STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
    // Only a word that has matched itself long enough may be accepted.
    if ((sync2_q == prev_q) && (stab_cnt_d == STAB_MAX)) begin
      stable_d = prev_q;
    end
  end

  always_comb begin
    div_d       = tick ? '0 : div_q + 1'b1;
    samp_d      = samp_q;
    acc_d       = acc_q;
    avg_y_d     = avg_y_q;
    avg_valid_d = 1'b0;
    state_d     = state_q;
    if (tick) begin
      samp_d = samp_q + 1'b1;
      acc_d  = sum;
    end
    if (block_done) begin
      acc_d       = '0;
      avg_y_d     = avg;
      avg_valid_d = 1'b1;
      unique case (state_q)
        ST_CENTER: begin
          if (avg_ext >= ENTER_P)      state_d = ST_LEFT;
          else if (avg_ext <= ENTER_N) state_d = ST_RIGHT;
        end
        ST_LEFT: begin
          if (avg_ext <= ENTER_N)      state_d = ST_RIGHT;
          else if (avg_ext < EXIT_P)   state_d = ST_CENTER;
        end
        ST_RIGHT: begin
          if (avg_ext >= ENTER_P)      state_d = ST_LEFT;
          else if (avg_ext > EXIT_N)   state_d = ST_CENTER;
        end
        default: state_d = ST_CENTER;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      stab_cnt_q  <= '0;
      stable_q    <= '0;
      div_q       <= '0;
      samp_q      <= '0;
      acc_q       <= '0;
      avg_y_q     <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= ST_CENTER;
    end else begin
      sync1_q     <= acl_data;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      stab_cnt_q  <= stab_cnt_d;
      stable_q    <= stable_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      acc_q       <= acc_d;
      avg_y_q     <= avg_y_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
    end
  end

  assign tilt_left  = (state_q == ST_LEFT);
  assign tilt_right = (state_q == ST_RIGHT);
  assign avg_y      = avg_y_q;
  assign avg_valid  = avg_valid_q;
  assign acl_stable = stable_q;

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Directed bench for acl_tilt_filter with a short sample period so whole
// averaging blocks complete quickly; expected values are hand-computed.
module tb_acl_tilt_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] acl_data = '0;
  logic        tilt_left, tilt_right, avg_valid;
  logic [4:0]  avg_y;
  logic [14:0] acl_stable;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acl_tilt_filter #(
    .SAMPLE_DIV(16), .AVG_LOG2(3), .ENTER_TH(4), .EXIT_TH(2), .STABLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .acl_data(acl_data),
    .tilt_left(tilt_left), .tilt_right(tilt_right),
    .avg_y(avg_y), .avg_valid(avg_valid), .acl_stable(acl_stable)
  );

  function automatic logic [14:0] mk(input logic [4:0] y);
    return {5'b01001, y, 5'b10001};
  endfunction

  // Waits for the next avg_valid pulse (sampled on negedge); reports clocks waited.
  task automatic wait_avg(input string tag, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int i = 1; i <= 400 && !ok; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        ok = 1;
        cycles = i;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: avg_valid not seen, got none required pulse within 400 clks", tag);
    end
  endtask

  // Called on the negedge where avg_valid was seen, so the whole next block uses y.
  task automatic run_block(input logic [4:0] y, input string tag);
    int c;
    acl_data = mk(y);
    wait_avg(tag, c);
    $display("block %s: y_in=%b avg_y=%b left=%b right=%b", tag, y, avg_y, tilt_left, tilt_right);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    acl_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tilt_left, tilt_right, avg_valid, avg_y, acl_stable} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {tilt_left, tilt_right, avg_valid, avg_y, acl_stable});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_y_plus5();
    int c;
    acl_data = mk(5'b00101);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (acl_stable !== 15'd0) begin
      n_fail++;
      $display("FAIL stable_early: got %h required 0000", acl_stable);
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (acl_stable !== mk(5'b00101)) begin
      n_fail++;
      $display("FAIL stable_load: got %h required %h", acl_stable, mk(5'b00101));
    end
    wait_avg("plus5", c);
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL plus5_avg: got avg=%b l=%b r=%b required avg=00101 l=1 r=0",
               avg_y, tilt_left, tilt_right);
    end
    @(negedge clk);
    n_cmp++;
    if (avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse_width: got %b required 0", avg_valid);
    end
    // Realign to a block boundary with a full block of +5.
    wait_avg("realign", c);
    n_cmp++;
    if (c !== 127) begin
      n_fail++;
      $display("FAIL valid_period: got %0d required 127", c);
    end
  endtask

  task automatic test_hysteresis();
    run_block(5'b00011, "left_plus3");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00011, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_plus3: got avg=%b l=%b r=%b required 00011 1 0", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b00010, "left_plus2");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_exit_th: got avg=%b l=%b r=%b required 00010 1 0", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b00001, "left_plus1");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00001, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL release_center: got avg=%b l=%b r=%b required 00001 0 0", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b00100, "enter_plus4");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL enter_th_left: got avg=%b l=%b r=%b required 00100 1 0", avg_y, tilt_left, tilt_right);
    end
  endtask

  task automatic test_swap();
    run_block(5'b11011, "swap_minus5");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b11011, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL swap_right: got avg=%b l=%b r=%b required 11011 0 1", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b11110, "right_minus2");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b11110, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_right: got avg=%b l=%b r=%b required 11110 0 1", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b11111, "right_minus1");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b11111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL release_right: got avg=%b l=%b r=%b required 11111 0 0", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b11100, "enter_minus4");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b11100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL enter_th_right: got avg=%b l=%b r=%b required 11100 0 1", avg_y, tilt_left, tilt_right);
    end
  endtask

  task automatic test_mixed();
    int c;
    // Four ticks of +3 then four of -4: sum -4, floor(-4/8) = -1.
    acl_data = mk(5'b00011);
    repeat (64) @(posedge clk);
    #1;
    acl_data = mk(5'b11100);
    wait_avg("mixed", c);
    $display("block mixed: avg_y=%b left=%b right=%b", avg_y, tilt_left, tilt_right);
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b11111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mixed_floor: got avg=%b l=%b r=%b required 11111 0 0", avg_y, tilt_left, tilt_right);
    end
    run_block(5'b10000, "min16");
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b10000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL min16: got avg=%b l=%b r=%b required 10000 0 1", avg_y, tilt_left, tilt_right);
    end
  endtask

  task automatic test_toggle();
    bit seen = 0;
    bit moved = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      acl_data = i[0] ? mk(5'b00111) : mk(5'b00110);
      @(negedge clk);
      if (acl_stable !== mk(5'b10000)) moved = 1;
      if (avg_valid) seen = 1;
    end
    $display("block toggle: avg_y=%b left=%b right=%b stable=%h", avg_y, tilt_left, tilt_right, acl_stable);
    n_cmp++;
    if (!seen || moved || acl_stable !== mk(5'b10000)) begin
      n_fail++;
      $display("FAIL toggle_stable: got seen=%b moved=%b stable=%h required 1 0 %h",
               seen, moved, acl_stable, mk(5'b10000));
    end
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b10000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL toggle_avg: got avg=%b l=%b r=%b required 10000 0 1", avg_y, tilt_left, tilt_right);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    acl_data = mk(5'b00101);
    repeat (37) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tilt_left, tilt_right, avg_valid, avg_y, acl_stable} !== 23'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0",
               {tilt_left, tilt_right, avg_valid, avg_y, acl_stable});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_avg("post_reset", c);
    $display("block post_reset: clks=%0d avg_y=%b left=%b right=%b", c, avg_y, tilt_left, tilt_right);
    n_cmp++;
    if (c !== 128) begin
      n_fail++;
      $display("FAIL reset_latency: got %0d clks required 128", c);
    end
    n_cmp++;
    if ({avg_y, tilt_left, tilt_right} !== {5'b00101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_avg: got avg=%b l=%b r=%b required 00101 1 0", avg_y, tilt_left, tilt_right);
    end
  endtask

  always @(negedge clk) begin
    if (tilt_left && tilt_right) begin
      n_cmp++;
      n_fail++;
      $display("FAIL onehot: got left=1 right=1 required not both");
    end
  end

  initial begin
    test_reset();
    test_y_plus5();
    test_hysteresis();
    test_swap();
    test_mixed();
    test_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
